// File: rtl/barrel_shifter_ctrl.sv
// rtl/barrel_shifter_ctrl.sv - two-stage valid/ready wrapper around the 8-bit rotate datapath
module barrel_shifter_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [7:0]       i_data,
  input  logic [4:0]       i_amt,
  input  logic             i_dir,
  output logic [7:0]       o_sh_a,
  output logic [2:0]       o_sh_k,
  input  logic [7:0]       i_sh_y,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [7:0]       o_data,
  output logic [2:0]       o_k_eff,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cnt
);

  // Stage 1 holds the operands presented to the shifter.
  logic             v1_q, v1_d;
  logic [7:0]       a1_q, a1_d;
  logic [2:0]       k1_q, k1_d;
  // Stage 2 captures the shifter result for the consumer.
  logic             v2_q, v2_d;
  logic [7:0]       y2_q, y2_d;
  logic [2:0]       k2_q, k2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] k_eff;
  logic       adv2;
  logic       acc;
  logic       out_hs;

  // Fold direction into a right-rotate amount; a left rotate by n is a right rotate by -n mod 8.
  always_comb begin
    k_eff = i_dir ? (3'd0 - i_amt[2:0]) : i_amt[2:0];
  end

  // Handshake control: S2 can move when empty or being drained; S1 can load when S2 makes room.
  always_comb begin
    adv2    = ~v2_q | i_ready;
    o_ready = ~i_rst & (~v1_q | adv2);
    acc     = i_valid & o_ready;
    out_hs  = v2_q & i_ready;
  end

  // Next-state for both pipeline stages and the completion counter.
  always_comb begin
    v1_d  = v1_q;
    a1_d  = a1_q;
    k1_d  = k1_q;
    v2_d  = v2_q;
    y2_d  = y2_q;
    k2_d  = k2_q;
    cnt_d = cnt_q;

    if (acc) begin
      v1_d = 1'b1;
      a1_d = i_data;
      k1_d = k_eff;
    end else if (adv2) begin
      v1_d = 1'b0;
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        y2_d = i_sh_y;
        k2_d = k1_q;
      end
    end

    if (out_hs) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q  <= 1'b0;
      a1_q  <= 8'h00;
      k1_q  <= 3'd0;
      v2_q  <= 1'b0;
      y2_q  <= 8'h00;
      k2_q  <= 3'd0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      a1_q  <= a1_d;
      k1_q  <= k1_d;
      v2_q  <= v2_d;
      y2_q  <= y2_d;
      k2_q  <= k2_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs come straight from registers, keeping input data paths off the outputs.
  always_comb begin
    o_sh_a  = a1_q;
    o_sh_k  = k1_q;
    o_valid = v2_q;
    o_data  = y2_q;
    o_k_eff = k2_q;
    o_busy  = v1_q | v2_q;
    o_cnt   = cnt_q;
  end

endmodule
